// File: rtl/draw_pkg.sv
// Shared constants and FSM state type for the VGA draw engine.
package draw_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned BLOCK    = 4;
  localparam int unsigned GRID_W   = SCREEN_W / BLOCK;
  localparam int unsigned GRID_H   = SCREEN_H / BLOCK;
  localparam int unsigned BLOCK_LOG = $clog2(BLOCK);

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLOCK,
    ST_CLEAR,
    ST_FINISH
  } draw_state_e;

endpackage

// File: rtl/pixel_sweep.sv
// 2-D raster counter: walks a width x height rectangle from a base point,
// x fastest, holding absolute coordinates in registers.
module pixel_sweep (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] base_x_i,
  input  logic [6:0] base_y_i,
  input  logic [7:0] width_i,
  input  logic [6:0] height_i,
  input  logic       step_i,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic       last_o
);

  logic [7:0] x_q, x_d, bx_q, bx_d, ox_q, ox_d, w_q, w_d;
  logic [6:0] y_q, y_d, oy_q, oy_d, h_q, h_d;
  logic       row_end;

  assign row_end = (ox_q == w_q - 8'd1);
  assign last_o  = row_end && (oy_q == h_q - 7'd1);
  assign x_o     = x_q;
  assign y_o     = y_q;

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    bx_d = bx_q;
    ox_d = ox_q;
    oy_d = oy_q;
    w_d  = w_q;
    h_d  = h_q;
    if (load_i) begin
      x_d  = base_x_i;
      y_d  = base_y_i;
      bx_d = base_x_i;
      ox_d = '0;
      oy_d = '0;
      w_d  = width_i;
      h_d  = height_i;
    end else if (step_i) begin
      if (row_end) begin
        ox_d = '0;
        x_d  = bx_q;
        oy_d = oy_q + 7'd1;
        y_d  = y_q + 7'd1;
      end else begin
        ox_d = ox_q + 8'd1;
        x_d  = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q  <= '0;
      y_q  <= '0;
      bx_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
      w_q  <= '0;
      h_q  <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      bx_q <= bx_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
      w_q  <= w_d;
      h_q  <= h_d;
    end
  end

endmodule

// File: rtl/vga_draw_engine.sv
// Expands block-draw / full-clear commands into a one-pixel-per-clock plot
// stream for the vga_adapter (160x120, 3-bit colour).
module vga_draw_engine
  import draw_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_clear,
  input  logic [5:0] req_cell_x,
  input  logic [4:0] req_cell_y,
  input  logic [2:0] req_colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  draw_state_e state_q;
  logic [2:0]  colour_q;
  logic        plot_q, done_q;

  logic       hs, in_range, sweep_load, sweep_step, sweep_last;
  logic [7:0] base_x, width;
  logic [6:0] base_y, height;

  assign req_ready  = (state_q == ST_IDLE) && !reset;
  assign hs         = req_valid && req_ready;
  assign in_range   = (req_cell_x < 6'(GRID_W)) && (req_cell_y < 5'(GRID_H));
  assign sweep_load = hs && (req_clear || in_range);
  assign sweep_step = ((state_q == ST_BLOCK) || (state_q == ST_CLEAR)) && !sweep_last;

  assign base_x = req_clear ? '0 : (8'(req_cell_x) << BLOCK_LOG);
  assign base_y = req_clear ? '0 : (7'(req_cell_y) << BLOCK_LOG);
  assign width  = req_clear ? 8'(SCREEN_W) : 8'(BLOCK);
  assign height = req_clear ? 7'(SCREEN_H) : 7'(BLOCK);

  // The sweep is loaded on the handshake edge so pixel 0 is already on x/y
  // in the cycle plot first rises; it then steps once per plotted pixel.
  pixel_sweep u_sweep (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (sweep_load),
    .base_x_i (base_x),
    .base_y_i (base_y),
    .width_i  (width),
    .height_i (height),
    .step_i   (sweep_step),
    .x_o      (x),
    .y_o      (y),
    .last_o   (sweep_last)
  );

  assign colour = colour_q;
  assign plot   = plot_q;
  assign done   = done_q;
  assign busy   = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          plot_q <= 1'b0;
          done_q <= 1'b0;
          if (hs) begin
            if (req_clear || in_range) begin
              state_q  <= req_clear ? ST_CLEAR : ST_BLOCK;
              colour_q <= req_colour;
              plot_q   <= 1'b1;
            end else begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        ST_BLOCK, ST_CLEAR: begin
          if (sweep_last) begin
            state_q <= ST_FINISH;
            plot_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            plot_q <= 1'b1;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          plot_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          plot_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
